// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider / enable generator
// Each channel divides clock by (div+1) with toggle or pulse output; divisor updates are shadowed to period boundaries.
module clk_div_multi #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_W     = $clog2(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_mode,
  input  logic                cfg_en,
  output logic [CHANNELS-1:0] clock_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0] div_q, div_d;
  logic [CHANNELS-1:0][WIDTH-1:0] sdiv_q, sdiv_d;
  logic [CHANNELS-1:0]            mode_q, mode_d;
  logic [CHANNELS-1:0]            smode_q, smode_d;
  logic [CHANNELS-1:0]            en_q, en_d;
  logic [CHANNELS-1:0]            pend_q, pend_d;
  logic [CHANNELS-1:0]            out_q, out_d;
  logic [CHANNELS-1:0]            tick_q, tick_d;
  logic [CHANNELS-1:0]            wr_sel;
  logic [CHANNELS-1:0]            term;

  // Out-of-range channel selects match no channel, so they are silently dropped.
  always_comb begin
    wr_sel = '0;
    term   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_sel[i] = cfg_we && (int'(cfg_ch) == i);
      term[i]   = en_q[i] && (cnt_q[i] == div_q[i]);
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    sdiv_d  = sdiv_q;
    mode_d  = mode_q;
    smode_d = smode_q;
    en_d    = en_q;
    pend_d  = pend_q;
    out_d   = out_q;
    tick_d  = tick_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (en_q[i]) begin
        if (term[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          out_d[i]  = mode_q[i] ? 1'b1 : ~out_q[i];
          if (pend_q[i]) begin
            div_d[i]  = sdiv_q[i];
            mode_d[i] = smode_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i]  = cnt_q[i] + WIDTH'(1);
          tick_d[i] = 1'b0;
          out_d[i]  = mode_q[i] ? 1'b0 : out_q[i];
        end
      end else begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b0;
        out_d[i]  = 1'b0;
        pend_d[i] = 1'b0;
      end

      // A write on a terminal edge lands after the apply above, so the old shadow wins that edge.
      if (wr_sel[i]) begin
        en_d[i] = cfg_en;
        if (!en_q[i] || !cfg_en) begin
          div_d[i]   = cfg_div;
          mode_d[i]  = cfg_mode;
          sdiv_d[i]  = cfg_div;
          smode_d[i] = cfg_mode;
          pend_d[i]  = 1'b0;
          cnt_d[i]   = '0;
          out_d[i]   = 1'b0;
          tick_d[i]  = 1'b0;
        end else begin
          sdiv_d[i]  = cfg_div;
          smode_d[i] = cfg_mode;
          pend_d[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      div_q   <= '1;
      sdiv_q  <= '1;
      mode_q  <= '0;
      smode_q <= '0;
      en_q    <= '1;
      pend_q  <= '0;
      out_q   <= '0;
      tick_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sdiv_q  <= sdiv_d;
      mode_q  <= mode_d;
      smode_q <= smode_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
    end
  end

  assign clock_out = out_q;
  assign tick      = tick_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
// Five channels so that channel selects 5..7 are out of range.
module tb_clk_div_multi;

  localparam int WIDTH = 16;
  localparam int CHANNELS = 5;
  localparam int CH_W = $clog2(CHANNELS);

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                cfg_we = 1'b0;
  logic [CH_W-1:0]     cfg_ch = '0;
  logic [WIDTH-1:0]    cfg_div = '0;
  logic                cfg_mode = 1'b0;
  logic                cfg_en = 1'b0;
  logic [CHANNELS-1:0] clock_out;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_en(cfg_en),
    .clock_out(clock_out), .tick(tick), .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(input int ch, input int dv, input logic md, input logic en);
    cfg_we   = 1'b1;
    cfg_ch   = CH_W'(ch);
    cfg_div  = WIDTH'(dv);
    cfg_mode = md;
    cfg_en   = en;
    step(1);
    cfg_we   = 1'b0;
  endtask

  initial begin
    // reset state and legacy free-running divide
    step(1);
    chk("rst_clock_out", clock_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_pending", pending, 0);
    reset = 1'b1;
    step(65535);
    chk("legacy_pre_tick", tick, 0);
    chk("legacy_pre_out", clock_out, 0);
    step(1);
    chk("legacy_tick", tick, 5'b11111);
    chk("legacy_out", clock_out, 5'b11111);
    chk("legacy_pending", pending, 0);
    step(1);
    chk("legacy_tick_drop", tick, 0);
    chk("legacy_out_hold", clock_out, 5'b11111);

    // ch1 enabled from disabled, D=3 toggle
    wr(1, 0, 1'b0, 1'b0);
    chk("ch1_disabled_out", clock_out[1], 0);
    wr(1, 3, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      chk($sformatf("ch1_tick_k%0d", k), tick[1], (k % 4) == 0);
      chk($sformatf("ch1_out_k%0d", k), clock_out[1], (k / 4) % 2);
      chk($sformatf("ch0_untouched_k%0d", k), {tick[0], clock_out[0]}, 2'b01);
    end

    // ch2 pulse D=4, then D=1 mid-period
    wr(2, 0, 1'b0, 1'b0);
    wr(2, 4, 1'b1, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      chk($sformatf("ch2_tick_k%0d", k), tick[2], k == 5);
      chk($sformatf("ch2_out_k%0d", k), clock_out[2], k == 5);
    end
    wr(2, 1, 1'b1, 1'b1);
    chk("ch2_pend_k8", pending[2], 1);
    chk("ch2_tick_k8", tick[2], 0);
    step(1);
    chk("ch2_pend_k9", pending[2], 1);
    chk("ch2_tick_k9", tick[2], 0);
    step(1);
    chk("ch2_tick_k10", tick[2], 1);
    chk("ch2_out_k10", clock_out[2], 1);
    chk("ch2_pend_k10", pending[2], 0);
    for (int k = 11; k <= 16; k++) begin
      step(1);
      chk($sformatf("ch2_tick_k%0d", k), tick[2], (k % 2) == 0);
      chk($sformatf("ch2_out_k%0d", k), clock_out[2], (k % 2) == 0);
    end

    // D=0 on ch1: toggle is clock/2, pulse holds high
    wr(1, 0, 1'b0, 1'b0);
    wr(1, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk($sformatf("d0_tog_out_k%0d", k), clock_out[1], k % 2);
      chk($sformatf("d0_tog_tick_k%0d", k), tick[1], 1);
    end
    wr(1, 0, 1'b1, 1'b0);
    wr(1, 0, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk($sformatf("d0_pls_out_k%0d", k), clock_out[1], 1);
      chk($sformatf("d0_pls_tick_k%0d", k), tick[1], 1);
    end

    // ch0: pending write, disable mid-period, re-enable with D=2
    wr(0, 5, 1'b0, 1'b1);
    chk("ch0_pend_set", pending[0], 1);
    wr(0, 0, 1'b0, 1'b0);
    chk("ch0_dis_out", clock_out[0], 0);
    chk("ch0_dis_tick", tick[0], 0);
    chk("ch0_dis_pend", pending[0], 0);
    step(2);
    chk("ch0_dis_hold", {clock_out[0], tick[0]}, 0);
    wr(0, 2, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      chk($sformatf("ch0_tick_k%0d", k), tick[0], (k % 3) == 0);
      chk($sformatf("ch0_out_k%0d", k), clock_out[0], (k / 3) % 2);
    end

    // ch3: write collides with terminal edge while pending
    wr(3, 0, 1'b0, 1'b0);
    wr(3, 3, 1'b0, 1'b1);
    step(1);
    wr(3, 5, 1'b0, 1'b1);
    chk("ch3_pend_k2", pending[3], 1);
    chk("ch3_tick_k2", tick[3], 0);
    step(1);
    chk("ch3_tick_k3", tick[3], 0);
    wr(3, 2, 1'b0, 1'b1);
    chk("ch3_tick_k4", tick[3], 1);
    chk("ch3_out_k4", clock_out[3], 1);
    chk("ch3_pend_k4", pending[3], 1);
    for (int k = 5; k <= 9; k++) begin
      step(1);
      chk($sformatf("ch3_tick_k%0d", k), tick[3], 0);
      chk($sformatf("ch3_pend_k%0d", k), pending[3], 1);
    end
    step(1);
    chk("ch3_tick_k10", tick[3], 1);
    chk("ch3_out_k10", clock_out[3], 0);
    chk("ch3_pend_k10", pending[3], 0);
    step(2);
    chk("ch3_tick_k12", tick[3], 0);

    // out-of-range channel writes change nothing
    wr(5, 0, 1'b0, 1'b0);
    chk("bad_ch_k13_tick3", tick[3], 1);
    chk("bad_ch_k13_out3", clock_out[3], 1);
    wr(7, 0, 1'b0, 1'b0);
    chk("bad_ch_k14_tick3", tick[3], 0);
    chk("bad_ch_k14_out3", clock_out[3], 1);
    chk("bad_ch_ch1_held", {clock_out[1], tick[1]}, 2'b11);
    chk("bad_ch_ch4_out", clock_out[4], 1);
    chk("bad_ch_pending", pending, 0);
    step(2);
    chk("bad_ch_k16_tick3", tick[3], 1);
    chk("bad_ch_k16_out3", clock_out[3], 0);

    // asynchronous reset assertion between edges
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_out", clock_out, 0);
    chk("async_rst_tick", tick, 0);
    chk("async_rst_pend", pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider/enable generator and successor to the single fixed divide-by-2^17 toggle divider. Each of CHANNELS independent channels divides `clock` by a runtime-programmable WIDTH-bit divisor and produces either a toggle (≈50 % duty) or single-cycle pulse output, plus a one-cycle `tick` strobe for enabling downstream logic. Divisor and mode updates are shadowed and take effect only at a period boundary, so outputs never glitch. Out of reset, every channel reproduces the legacy behaviour: it free-runs in toggle mode with divisor all-ones.

## Interface
- WIDTH, 16, counter/divisor width in bits (≥2)
- CHANNELS, 4, number of independent channels (≥2)
- CH_W, $clog2(CHANNELS), width of channel select (derived)

- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); one clock, no other reset
- cfg_we  in  1  config write strobe, sampled each rising edge
- cfg_ch  in  CH_W  target channel; values ≥ CHANNELS are ignored (no state change)
- cfg_div  in  WIDTH  divisor D; period is D+1 clocks per terminal count
- cfg_mode  in  1  0 = toggle output, 1 = pulse output
- cfg_en  in  1  channel enable
- clock_out  out  CHANNELS  divided outputs, one bit per channel, registered
- tick  out  CHANNELS  one-cycle strobe per terminal count, registered
- pending  out  CHANNELS  1 = shadow divisor/mode written but not yet applied

## Operation
- Per-channel state: cnt[WIDTH], active div/mode, shadow div/mode, en, pending, out.
- Reset (reset=0, async): cnt=0, active = shadow = all-ones div with mode 0, en=1, pending=0, clock_out=0, tick=0.
- Counting (en=1): cnt increments by 1 each clock; terminal when cnt == active div. On the terminal edge: cnt←0, tick←1 (for that one cycle only), mode 0: out←~out, mode 1: out←1 (out←0 on every non-terminal edge).
- Period: toggle mode gives an output period of 2·(D+1) clocks; pulse mode gives one high cycle every D+1 clocks. D=0: toggle = clock/2; pulse = clock_out held 1, tick held 1.
- Config write (cfg_we=1, cfg_ch valid):
  - en←cfg_en immediately.
  - If the channel was disabled or is being disabled: active div/mode load directly, pending←0.
  - Otherwise (enabled→enabled): shadow←cfg_div/cfg_mode, pending←1.
- Apply: on a terminal edge with pending=1, active←shadow and pending←0. The new divisor governs the period that starts at that edge.
- Disabled channel: cnt held 0, clock_out=0, tick=0, pending=0. Disabling forces all three to 0 on the next edge, including mid-period.
- Enable (0→1 write): cnt starts from 0 on that edge, and clock_out starts from 0.
- Collision (write to channel X on X's terminal edge, X enabled): the terminal applies the shadow value held before the edge (if pending); the new write lands in shadow with pending=1 and is applied at the following terminal.
- Channels are fully independent; only one channel is written per cycle.
- Counter arithmetic is unsigned modulo 2^WIDTH. cnt never exceeds active div, so no wrap past all-ones.

## Timing
- Write edge E (enable or direct load): first tick is high for the cycle following edge E+D+1; thereafter every D+1 edges.
- tick and clock_out change on the same edge; both are flop outputs, with no combinational path from inputs.
- pending rises on the edge after the write and falls on the applying terminal edge.
- Reset assertion clears all outputs immediately (async). Deassertion is assumed synchronised externally; the first count occurs on the first edge after release.

## Test plan
- Reset release, no writes: every channel toggles clock_out every 65536 clocks (period 131072); tick pulses every 65536; pending=0.
- Write ch1 en=1 D=3 mode=0 while ch1 is disabled: tick[1] every 4 clocks, clock_out[1] period 8, duty 4/4; other channels unaffected.
- Write ch2 D=4 mode=1 at cycle 0 from disabled, then D=1 mid-period: pending[2]=1 until the next terminal; pulses are 5 clocks apart before the update and 2 clocks apart after it, with no short pulse.
- D=0: toggle mode → clock_out=clock/2; pulse mode → clock_out and tick held high.
- Disable ch0 mid-period, then re-enable with D=2: clock_out[0]/tick[0]=0 the edge after disable; after enable, first tick 3 edges later.
- Write to ch3 exactly on its terminal edge while pending: the old shadow applies, pending stays 1, and the new value applies at the next terminal. Write with cfg_ch ≥ CHANNELS: no state change anywhere.
